// File: rtl/fixed_pkg.sv
// rtl/fixed_pkg.sv - fixed-point types, saturating arithmetic and Newton seed table
package fixed_pkg;

    localparam int B  = 20;
    localparam int D  = 8;
    localparam int MW = $clog2(B);

    typedef logic signed [B-1:0]   fixed;
    typedef logic signed [2*B-1:0] fixed_wide;

    localparam fixed FIXED_1   = fixed'(1 << D);
    localparam fixed FIXED_1_5 = fixed'(3 << (D - 1));
    localparam fixed FIXED_2   = fixed'(2 << D);
    localparam fixed FIXED_MAX = {1'b0, {(B-1){1'b1}}};
    localparam fixed FIXED_MIN = {1'b1, {(B-1){1'b0}}};

    localparam fixed_wide WIDE_MAX = fixed_wide'(FIXED_MAX);
    localparam fixed_wide WIDE_MIN = fixed_wide'(FIXED_MIN);

    typedef enum logic {
        NEWTON_RECIP    = 1'b0,
        NEWTON_INV_SQRT = 1'b1
    } newton_mode_e;

    // Arithmetic result with a flag raised when the value was clamped.
    typedef struct packed {
        fixed v;
        logic sat;
    } fixed_res_t;

    // Per-sample state carried down the iteration pipeline.
    typedef struct packed {
        fixed         a;
        fixed         y;
        newton_mode_e mode;
        logic         sign;
        logic         zero;
        logic         neg;
        logic         err;
    } newton_state_t;

    // Seeds indexed by [mode][leading-one position of |x|].
    // recip: 0.75*2^-(m-D), inv_sqrt: 0.8*2^-((m-D)/2), rounded, clamped to [1, max].
    localparam fixed SEED [2][B] = '{
        '{20'sd49152, 20'sd24576, 20'sd12288, 20'sd6144, 20'sd3072,
          20'sd1536,  20'sd768,   20'sd384,   20'sd192,  20'sd96,
          20'sd48,    20'sd24,    20'sd12,    20'sd6,    20'sd3,
          20'sd2,     20'sd1,     20'sd1,     20'sd1,    20'sd1},
        '{20'sd3277,  20'sd2317,  20'sd1638,  20'sd1159, 20'sd819,
          20'sd579,   20'sd410,   20'sd290,   20'sd205,  20'sd145,
          20'sd102,   20'sd72,    20'sd51,    20'sd36,   20'sd26,
          20'sd18,    20'sd13,    20'sd9,     20'sd6,    20'sd5}
    };

    function automatic fixed_res_t sat_narrow(input fixed_wide w);
        fixed_res_t r;
        if (w > WIDE_MAX) begin
            r.v   = FIXED_MAX;
            r.sat = 1'b1;
        end else if (w < WIDE_MIN) begin
            r.v   = FIXED_MIN;
            r.sat = 1'b1;
        end else begin
            r.v   = w[B-1:0];
            r.sat = 1'b0;
        end
        return r;
    endfunction

    function automatic fixed_res_t fadd_sat(input fixed a, input fixed b);
        fixed_wide w;
        w = fixed_wide'(a) + fixed_wide'(b);
        return sat_narrow(w);
    endfunction

    function automatic fixed_res_t fsub_sat(input fixed a, input fixed b);
        fixed_wide w;
        w = fixed_wide'(a) - fixed_wide'(b);
        return sat_narrow(w);
    endfunction

    // Full-width product, rescaled by D, then clamped instead of wrapped.
    function automatic fixed_res_t fmul_sat(input fixed a, input fixed b);
        fixed_wide p;
        p = fixed_wide'(a) * fixed_wide'(b);
        return sat_narrow(p >>> D);
    endfunction

    // Position of the most significant set bit; 0 for a zero operand.
    function automatic logic [MW-1:0] lead_one(input fixed a);
        logic [MW-1:0] m;
        m = '0;
        for (int i = 0; i < B; i++) begin
            if (a[i]) m = MW'(i);
        end
        return m;
    endfunction

endpackage

// File: rtl/newton_iter_stage.sv
// rtl/newton_iter_stage.sv - one Newton-Raphson iteration as two enabled pipeline stages
module newton_iter_stage
    import fixed_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             en_i,
    input  logic             valid_i,
    input  newton_state_t    st_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    output newton_state_t    st_o,
    output logic [TAG_W-1:0] tag_o
);

    logic             a_valid_q;
    newton_state_t    a_st_q, a_st_d;
    logic [TAG_W-1:0] a_tag_q;
    fixed             a_t_q, a_t_d;
    fixed             a_h_q, a_h_d;

    logic             b_valid_q;
    newton_state_t    b_st_q, b_st_d;
    logic [TAG_W-1:0] b_tag_q;

    // Stage A: t = a*y for reciprocal, s = y*y and h = a/2 for inverse sqrt.
    always_comb begin
        fixed_res_t prod;
        a_st_d = st_i;
        a_h_d  = $signed(st_i.a) >>> 1;
        if (st_i.mode == NEWTON_RECIP) begin
            prod = fmul_sat(st_i.a, st_i.y);
        end else begin
            prod = fmul_sat(st_i.y, st_i.y);
        end
        a_t_d      = prod.v;
        a_st_d.err = st_i.err | prod.sat;
    end

    // Stage A registers advance only with the shared pipeline enable.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            a_valid_q <= 1'b0;
            a_st_q    <= '0;
            a_tag_q   <= '0;
            a_t_q     <= '0;
            a_h_q     <= '0;
        end else if (en_i) begin
            a_valid_q <= valid_i;
            a_st_q    <= a_st_d;
            a_tag_q   <= tag_i;
            a_t_q     <= a_t_d;
            a_h_q     <= a_h_d;
        end
    end

    // Stage B: y' = y*(2 - t) or y' = y*(1.5 - s*h).
    always_comb begin
        fixed_res_t hs;
        fixed_res_t corr;
        fixed_res_t upd;
        hs = fmul_sat(a_t_q, a_h_q);
        if (a_st_q.mode == NEWTON_RECIP) begin
            corr = fsub_sat(FIXED_2, a_t_q);
        end else begin
            corr = fsub_sat(FIXED_1_5, hs.v);
        end
        upd        = fmul_sat(a_st_q.y, corr.v);
        b_st_d     = a_st_q;
        b_st_d.y   = upd.v;
        b_st_d.err = a_st_q.err | corr.sat | upd.sat
                   | ((a_st_q.mode == NEWTON_INV_SQRT) & hs.sat);
    end

    // Stage B registers advance only with the shared pipeline enable.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            b_valid_q <= 1'b0;
            b_st_q    <= '0;
            b_tag_q   <= '0;
        end else if (en_i) begin
            b_valid_q <= a_valid_q;
            b_st_q    <= b_st_d;
            b_tag_q   <= a_tag_q;
        end
    end

    assign valid_o = b_valid_q;
    assign st_o    = b_st_q;
    assign tag_o   = b_tag_q;

endmodule

// File: rtl/fixed_newton_unit.sv
// rtl/fixed_newton_unit.sv - stallable Newton-Raphson reciprocal / inverse square root pipe
module fixed_newton_unit
    import fixed_pkg::*;
#(
    parameter int N_ITER = 2,
    parameter int TAG_W  = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [B-1:0]     in_x,
    input  logic             in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [B-1:0]     out_y,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    logic en;

    logic             s0_valid_q;
    fixed             s0_a_q, s0_a_d;
    logic             s0_sign_q;
    logic             s0_sat_q, s0_sat_d;
    newton_mode_e     s0_mode_q;
    logic [TAG_W-1:0] s0_tag_q;

    logic             s1_valid_q;
    newton_state_t    s1_st_q, s1_st_d;
    logic [TAG_W-1:0] s1_tag_q;

    logic             it_valid [N_ITER+1];
    newton_state_t    it_st    [N_ITER+1];
    logic [TAG_W-1:0] it_tag   [N_ITER+1];

    // Whole pipe moves as one: it stalls only when a result is waiting downstream.
    assign en       = out_ready | ~out_valid;
    assign in_ready = en;

    // Magnitude of the operand; the most negative code has no positive twin and clamps.
    always_comb begin
        s0_a_d   = fixed'(in_x);
        s0_sat_d = 1'b0;
        if (in_x[B-1]) begin
            if (in_x == FIXED_MIN) begin
                s0_a_d   = FIXED_MAX;
                s0_sat_d = 1'b1;
            end else begin
                s0_a_d = -fixed'(in_x);
            end
        end
    end

    // S0: capture the accepted sample (bubbles enter as valid=0).
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            s0_valid_q <= 1'b0;
            s0_a_q     <= '0;
            s0_sign_q  <= 1'b0;
            s0_sat_q   <= 1'b0;
            s0_mode_q  <= NEWTON_RECIP;
            s0_tag_q   <= '0;
        end else if (en) begin
            s0_valid_q <= in_valid;
            s0_a_q     <= s0_a_d;
            s0_sign_q  <= in_x[B-1];
            s0_sat_q   <= s0_sat_d;
            s0_mode_q  <= newton_mode_e'(in_mode);
            s0_tag_q   <= in_tag;
        end
    end

    // Seed lookup and domain flags; special cases ride along instead of stalling.
    always_comb begin
        s1_st_d      = '0;
        s1_st_d.a    = s0_a_q;
        s1_st_d.y    = SEED[s0_mode_q][lead_one(s0_a_q)];
        s1_st_d.mode = s0_mode_q;
        s1_st_d.sign = s0_sign_q;
        s1_st_d.zero = (s0_a_q == '0);
        s1_st_d.neg  = (s0_mode_q == NEWTON_INV_SQRT) & s0_sign_q;
        s1_st_d.err  = s0_sat_q;
    end

    // S1: register the seeded state.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            s1_valid_q <= 1'b0;
            s1_st_q    <= '0;
            s1_tag_q   <= '0;
        end else if (en) begin
            s1_valid_q <= s0_valid_q;
            s1_st_q    <= s1_st_d;
            s1_tag_q   <= s0_tag_q;
        end
    end

    assign it_valid[0] = s1_valid_q;
    assign it_st[0]    = s1_st_q;
    assign it_tag[0]   = s1_tag_q;

    for (genvar g = 0; g < N_ITER; g++) begin : g_iter
        newton_iter_stage #(
            .TAG_W (TAG_W)
        ) u_iter (
            .clk_in  (clk_in),
            .rst_in  (rst_in),
            .en_i    (en),
            .valid_i (it_valid[g]),
            .st_i    (it_st[g]),
            .tag_i   (it_tag[g]),
            .valid_o (it_valid[g+1]),
            .st_o    (it_st[g+1]),
            .tag_o   (it_tag[g+1])
        );
    end

    assign out_valid = it_valid[N_ITER];
    assign out_tag   = it_tag[N_ITER];

    // Output formatting: restore the sign for reciprocals, substitute invalid-domain results.
    always_comb begin
        out_y   = it_st[N_ITER].y;
        out_err = it_st[N_ITER].err;
        if (it_st[N_ITER].zero) begin
            out_y   = FIXED_MAX;
            out_err = 1'b1;
        end else if (it_st[N_ITER].neg) begin
            out_y   = '0;
            out_err = 1'b1;
        end else if ((it_st[N_ITER].mode == NEWTON_RECIP) && it_st[N_ITER].sign) begin
            out_y = -it_st[N_ITER].y;
        end
    end

endmodule

// File: tb/tb_fixed_newton_unit.sv
// tb/tb_fixed_newton_unit.sv - directed self-checking bench for fixed_newton_unit
module tb_fixed_newton_unit;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] in_x;
    logic        in_mode;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] out_y;
    logic [3:0]  out_tag;
    logic        out_err;

    int errs   = 0;
    int checks = 0;

    always #5 clk_in = ~clk_in;

    fixed_newton_unit #(
        .N_ITER (2),
        .TAG_W  (4)
    ) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_tag   (out_tag),
        .out_err   (out_err)
    );

    typedef struct {
        logic [19:0] x;
        logic        mode;
        logic [19:0] y;
        logic        err;
        int          tol;
    } vec_t;

    vec_t       vtab [8];
    vec_t       sq [$];
    logic [3:0] tq [$];

    task automatic check(input string nm, input longint got, input longint exp, input longint tol);
        longint diff;
        checks++;
        diff = got - exp;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", nm, got, exp, tol);
        end
    endtask

    task automatic run_one(input string nm, input int vi, input logic [3:0] tag);
        int lat;
        @(posedge clk_in); #1;
        in_valid = 1'b1;
        in_x     = vtab[vi].x;
        in_mode  = vtab[vi].mode;
        in_tag   = tag;
        @(negedge clk_in);
        check({nm, "_accept"}, in_ready, 1, 0);
        @(posedge clk_in); #1;
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk_in);
            lat++;
        end while (!out_valid && lat < 20);
        check({nm, "_lat"}, lat, 6, 0);
        check({nm, "_y"}, $signed(out_y), $signed(vtab[vi].y), vtab[vi].tol);
        check({nm, "_tag"}, out_tag, tag, 0);
        check({nm, "_err"}, out_err, vtab[vi].err, 0);
        @(posedge clk_in); #1;
    endtask

    task automatic run_stream(input string nm, input bit bp, output int span);
        int  n;
        int  got;
        int  cyc;
        int  first_cyc;
        int  last_cyc;
        int  bad_rdy;
        bit  done;
        n = sq.size();
        got = 0; cyc = 0; first_cyc = 0; last_cyc = 0; bad_rdy = 0; done = 1'b0;
        fork
            begin
                int g;
                @(posedge clk_in); #1;
                for (int i = 0; i < n; i++) begin
                    in_valid = 1'b1;
                    in_x     = sq[i].x;
                    in_mode  = sq[i].mode;
                    in_tag   = tq[i];
                    g = 0;
                    @(negedge clk_in);
                    while (!in_ready && g < 500) begin
                        @(negedge clk_in);
                        g++;
                    end
                    @(posedge clk_in); #1;
                end
                in_valid = 1'b0;
            end
            begin
                while (got < n && cyc < 2000) begin
                    @(negedge clk_in);
                    cyc++;
                    if (in_ready !== (out_ready | ~out_valid)) bad_rdy++;
                    if (out_valid && out_ready) begin
                        check({nm, "_y"}, $signed(out_y), $signed(sq[got].y), sq[got].tol);
                        check({nm, "_tag"}, out_tag, tq[got], 0);
                        check({nm, "_err"}, out_err, sq[got].err, 0);
                        if (got == 0) first_cyc = cyc;
                        last_cyc = cyc;
                        got++;
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk_in); #1;
                    out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                out_ready = 1'b1;
            end
        join
        check({nm, "_count"}, got, n, 0);
        check({nm, "_in_ready_rule"}, bad_rdy, 0, 0);
        repeat (8) @(negedge clk_in);
        check({nm, "_drain"}, out_valid, 0, 0);
        span = last_cyc - first_cyc;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int span;
        int g;
        int stale;

        vtab[0] = '{20'h00200, 1'b0, 20'h00080, 1'b0, 2};
        vtab[1] = '{20'hFFC00, 1'b0, 20'hFFFC0, 1'b0, 2};
        vtab[2] = '{20'h00400, 1'b1, 20'h00080, 1'b0, 2};
        vtab[3] = '{20'h00040, 1'b1, 20'h00200, 1'b0, 2};
        vtab[4] = '{20'h00000, 1'b0, 20'h7FFFF, 1'b1, 0};
        vtab[5] = '{20'hFFF00, 1'b1, 20'h00000, 1'b1, 0};
        vtab[6] = '{20'h00100, 1'b0, 20'h00100, 1'b0, 1};
        vtab[7] = '{20'h00100, 1'b1, 20'h00100, 1'b0, 1};

        rst_in    = 1'b1;
        in_valid  = 1'b0;
        in_x      = '0;
        in_mode   = 1'b0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        check("rst_out_valid", out_valid, 0, 0);
        check("rst_out_y", out_y, 0, 0);
        check("rst_out_tag", out_tag, 0, 0);
        check("rst_out_err", out_err, 0, 0);
        check("rst_in_ready", in_ready, 1, 0);

        run_one("recip_2", 0, 4'd3);
        run_one("recip_m4", 1, 4'd5);
        run_one("isqrt_4", 2, 4'd6);
        run_one("isqrt_q", 3, 4'd9);

        sq.delete(); tq.delete();
        sq.push_back(vtab[4]); tq.push_back(4'd1);
        sq.push_back(vtab[0]); tq.push_back(4'd2);
        sq.push_back(vtab[5]); tq.push_back(4'd3);
        sq.push_back(vtab[2]); tq.push_back(4'd4);
        run_stream("domain", 1'b0, span);

        sq.delete(); tq.delete();
        for (int i = 0; i < 10; i++) begin
            sq.push_back(vtab[i % 8]);
            tq.push_back(4'(i));
        end
        run_stream("bp", 1'b1, span);

        sq.delete(); tq.delete();
        for (int i = 0; i < 8; i++) begin
            sq.push_back(vtab[6 + (i % 2)]);
            tq.push_back(4'(i));
        end
        run_stream("mix", 1'b0, span);
        check("mix_span", span, 7, 0);

        @(posedge clk_in); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_x     = vtab[0].x;
            in_mode  = vtab[0].mode;
            in_tag   = 4'(7 + i);
            @(posedge clk_in); #1;
        end
        in_valid = 1'b0;
        g = 0;
        while (!out_valid && g < 20) begin
            @(negedge clk_in);
            g++;
        end
        check("rst_mid_pre_valid", out_valid, 1, 0);
        @(posedge clk_in); #3;
        rst_in = 1'b1;
        #1;
        check("rst_mid_valid_drop", out_valid, 0, 0);
        check("rst_mid_y", out_y, 0, 0);
        check("rst_mid_tag", out_tag, 0, 0);
        @(posedge clk_in); #3;
        rst_in    = 1'b0;
        out_ready = 1'b1;
        stale = 0;
        repeat (12) begin
            @(negedge clk_in);
            if (out_valid) stale++;
        end
        check("rst_mid_stale", stale, 0, 0);
        run_one("post_rst", 0, 4'd4);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
